// File: rtl/eclair_dma_pkg.sv
// Shared definitions for the DMA channel arbiter: FSM state encoding,
// default watchdog limit and the grant-index width helper.
package eclair_dma_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      GRANTED = 2'd2,
      RELEASE = 2'd3
   } arb_state_e;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

   // Width of an index into a vector of n requesters (at least 1 bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dma_arbiter_if.sv
// Requester/CPU-side signal bundle of the DMA arbiter.
//   req         per-master level request        (into arbiter)
//   gnt         one-hot grant                   (from arbiter)
//   gnt_idx     current/last grantee index      (from arbiter)
//   dma_req     DMA request to the CPU          (from arbiter)
//   dma_ack     DMA acknowledge from the CPU    (into arbiter)
//   busy        arbiter not idle                (from arbiter)
//   timeout_err watchdog revoked a grant        (from arbiter)
// master: the arbiter's view; slave: the requesters' and CPU's view.
interface dma_arbiter_if
   import eclair_dma_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) ();

   localparam int unsigned IW = idx_width(NUM_REQ);

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]      gnt_idx;
   logic               dma_req;
   logic               dma_ack;
   logic               busy;
   logic               timeout_err;

   modport master (
      input  req, dma_ack,
      output gnt, gnt_idx, dma_req, busy, timeout_err
   );

   modport slave (
      output req, dma_ack,
      input  gnt, gnt_idx, dma_req, busy, timeout_err
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or after
// rr_ptr, wrapping modulo NUM_REQ.
//   eligible  in   candidate requesters
//   rr_ptr    in   index with highest priority
//   winner_c  out  chosen index (0 when none)
//   valid_c   out  at least one candidate
module rr_pick
   import eclair_dma_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned IW      = idx_width(NUM_REQ),
   localparam int unsigned SW      = IW + 1
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IW-1:0]      rr_ptr,
   output logic [IW-1:0]      winner_c,
   output logic               valid_c
);

   logic [SW-1:0] pos;

   // Walk from the lowest priority offset down so the nearest hit is kept.
   always_comb begin
      winner_c = '0;
      valid_c  = 1'b0;
      pos      = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         pos = {1'b0, rr_ptr} + SW'(i);
         if (pos >= SW'(NUM_REQ)) begin
            pos = pos - SW'(NUM_REQ);
         end
         if (eligible[pos[IW-1:0]]) begin
            valid_c  = 1'b1;
            winner_c = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/dma_arbiter.sv
// Shares the CPU's single DMA channel between NUM_REQ masters. Runs the
// dma_req/dma_ack handshake, grants one master per tenure in round-robin
// order and revokes a grant held longer than TIMEOUT_CYCLES.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   bus      master modport of dma_arbiter_if (req/dma_ack in;
//            gnt/gnt_idx/dma_req/busy/timeout_err out, all registered)
module dma_arbiter
   import eclair_dma_pkg::*;
#(
   parameter  int unsigned NUM_REQ        = 2,
   parameter  int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   localparam int unsigned CW             = $clog2(TIMEOUT_CYCLES + 1),
   localparam int unsigned IW             = idx_width(NUM_REQ)
) (
   input logic           clk,
   input logic           reset_n,
   dma_arbiter_if.master bus
);

   arb_state_e         state_q, state_n;
   logic [NUM_REQ-1:0] gnt_q, gnt_n;
   logic [IW-1:0]      idx_q, idx_n;
   logic               dreq_q, dreq_n;
   logic               busy_q, busy_n;
   logic               terr_q, terr_n;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_n;
   logic [CW-1:0]      wd_q, wd_n;
   logic [NUM_REQ-1:0] block_q, block_n;

   logic [NUM_REQ-1:0] eligible_c;
   logic [IW-1:0]      pick_idx_c;
   logic               pick_valid_c;
   logic               owner_req_c;

   assign eligible_c  = bus.req & ~block_q;
   assign owner_req_c = bus.req[idx_q];

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .eligible (eligible_c),
      .rr_ptr   (rr_ptr_q),
      .winner_c (pick_idx_c),
      .valid_c  (pick_valid_c)
   );

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         idx_q    <= '0;
         dreq_q   <= 1'b0;
         busy_q   <= 1'b0;
         terr_q   <= 1'b0;
         rr_ptr_q <= '0;
         wd_q     <= '0;
         block_q  <= '0;
      end else begin
         state_q  <= state_n;
         gnt_q    <= gnt_n;
         idx_q    <= idx_n;
         dreq_q   <= dreq_n;
         busy_q   <= busy_n;
         terr_q   <= terr_n;
         rr_ptr_q <= rr_ptr_n;
         wd_q     <= wd_n;
         block_q  <= block_n;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n  = state_q;
      gnt_n    = gnt_q;
      idx_n    = idx_q;
      dreq_n   = dreq_q;
      terr_n   = 1'b0;
      rr_ptr_n = rr_ptr_q;
      wd_n     = wd_q;
      // A blocked master regains eligibility once its req is seen low.
      block_n  = block_q & bus.req;

      unique case (state_q)
         IDLE: begin
            if (pick_valid_c) begin
               idx_n   = pick_idx_c;
               dreq_n  = 1'b1;
               state_n = REQUEST;
            end
         end
         REQUEST: begin
            if (!owner_req_c) begin
               dreq_n  = 1'b0;
               state_n = RELEASE;
            end else if (bus.dma_ack) begin
               gnt_n   = NUM_REQ'(1) << idx_q;
               wd_n    = '0;
               state_n = GRANTED;
            end
         end
         GRANTED: begin
            // Normal release (or CPU withdrawing ack) beats watchdog expiry.
            if (!owner_req_c || !bus.dma_ack) begin
               gnt_n   = '0;
               dreq_n  = 1'b0;
               state_n = RELEASE;
            end else if (wd_q == CW'(TIMEOUT_CYCLES - 1)) begin
               gnt_n          = '0;
               dreq_n         = 1'b0;
               terr_n         = 1'b1;
               block_n[idx_q] = 1'b1;
               state_n        = RELEASE;
            end else begin
               wd_n = wd_q + CW'(1);
            end
         end
         RELEASE: begin
            if (!bus.dma_ack) begin
               rr_ptr_n = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

   assign bus.gnt         = gnt_q;
   assign bus.gnt_idx     = idx_q;
   assign bus.dma_req     = dreq_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = terr_q;

endmodule
